// File: rtl/hv_sync_gen.sv
// Pixel-rate H/V timing generator: 9-bit line and frame counters advanced on
// falling edges of the sampled pixel clock, with registered blanking/sync/strobe decodes.
module hv_sync_gen #(
  parameter int H_TOTAL = 455,
  parameter int V_TOTAL = 262
) (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic       CLK,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       _256H,
  output logic       _256H_N,
  output logic       _4V,
  output logic       HBLANK,
  output logic       HBLANK_N,
  output logic       VBLANK,
  output logic       VBLANK_N,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       HRESET,
  output logic       VRESET
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

  logic       clk_q;
  logic       tick;
  logic [8:0] h_nxt;
  logic [8:0] v_nxt;

  assign tick = clk_q & ~CLK;

  always_comb begin
    h_nxt = HCNT;
    v_nxt = VCNT;
    if (tick) begin
      if (HCNT == H_LAST) begin
        h_nxt = 9'd0;
        v_nxt = (VCNT == V_LAST) ? 9'd0 : VCNT + 9'd1;
      end else begin
        h_nxt = HCNT + 9'd1;
      end
    end
  end

  // Decodes are taken from the next-count values so they land in the same
  // cycle as the counters and always match the visible count.
  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      clk_q  <= 1'b0;
      HCNT   <= 9'd0;
      VCNT   <= 9'd0;
      HBLANK <= 1'b1;
      HSYNC  <= 1'b0;
      HRESET <= 1'b0;
      VBLANK <= 1'b1;
      VSYNC  <= 1'b0;
      VRESET <= 1'b0;
    end else begin
      clk_q  <= CLK;
      HCNT   <= h_nxt;
      VCNT   <= v_nxt;
      HBLANK <= (h_nxt < 9'd80);
      HSYNC  <= (h_nxt >= 9'd32) && (h_nxt < 9'd64);
      HRESET <= (h_nxt == H_LAST);
      VBLANK <= (v_nxt < 9'd16);
      VSYNC  <= (v_nxt >= 9'd4) && (v_nxt < 9'd8);
      VRESET <= (v_nxt == V_LAST);
    end
  end

  assign _256H    = HCNT[8];
  assign _256H_N  = ~HCNT[8];
  assign _4V      = VCNT[2];
  assign HBLANK_N = ~HBLANK;
  assign VBLANK_N = ~VBLANK;

endmodule
